// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs one outstanding req/ack fetch at a time,
// and buffers up to two returned words for the IF_ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImReq,
    output logic [31:0] ImAddr,
    input  logic        ImAck,
    input  logic [31:0] ImData,
    output logic        OutValid,
    output logic [31:0] OutPC,
    output logic [31:0] OutAdd1,
    output logic [31:0] OutIns,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] add1;
        logic [31:0] ins;
    } entry_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    entry_t      q_q [2];
    entry_t      q_d [2];

    logic        pop, push, wr_sel;
    logic [31:0] fetch_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            count_q    <= 2'd0;
            q_q[0]     <= '0;
            q_q[1]     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            q_q[0]     <= q_d[0];
            q_q[1]     <= q_d[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        q_d[0]     = q_q[0];
        q_d[1]     = q_q[1];

        pop        = OutValid && !Stall && !BranchTaken;
        push       = ImAck && (state_q == BUSY) && !BranchTaken;
        fetch_addr = BranchTaken ? BranchTarget : pc_q;
        // Tail slot after the pop: count 2 only ever pushes together with a pop.
        wr_sel     = count_q[1] | (count_q[0] & !pop);

        if (BranchTaken) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q - {1'b0, pop} + {1'b0, push};
        end

        if (pop) begin
            q_d[0] = q_q[1];
        end
        if (push) begin
            q_d[wr_sel] = '{pc: req_addr_q, add1: req_addr_q + 32'd4, ins: ImData};
        end

        // A new request may only start once the current one has completed.
        if (state_q == IDLE || ImAck) begin
            if (count_d < 2'd2) begin
                state_d    = BUSY;
                req_addr_d = fetch_addr;
                pc_d       = fetch_addr + 32'd4;
            end else begin
                state_d = IDLE;
                if (BranchTaken) begin
                    pc_d = BranchTarget;
                end
            end
        end else if (BranchTaken) begin
            state_d = DROP;
            pc_d    = BranchTarget;
        end
    end

    assign ImReq    = (state_q != IDLE);
    assign ImAddr   = req_addr_q;
    assign OutValid = (count_q != 2'd0);
    assign OutPC    = OutValid ? q_q[0].pc   : 32'h0;
    assign OutAdd1  = OutValid ? q_q[0].add1 : 32'h0;
    assign OutIns   = OutValid ? q_q[0].ins  : 32'h0;
    assign DbgState = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/latency traffic,
// compared every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        ImAck = 1'b0;
    logic [31:0] ImData = 32'h0;
    logic        ImReq;
    logic [31:0] ImAddr;
    logic        OutValid;
    logic [31:0] OutPC, OutAdd1, OutIns;
    logic [1:0]  DbgState;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ImReq(ImReq), .ImAddr(ImAddr), .ImAck(ImAck),
        .ImData(ImData), .OutValid(OutValid), .OutPC(OutPC), .OutAdd1(OutAdd1),
        .OutIns(OutIns), .DbgState(DbgState)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 0;

    // Reference model: instruction queue, one outstanding fetch, next fetch address.
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_req;
    bit          m_busy, m_stale;

    // Memory responder state.
    bit mem_act, tie, lat_rand;
    int mem_left, lat;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = 32'h0;
        m_req   = 32'h0;
        m_busy  = 0;
        m_stale = 0;
    endtask

    task automatic model_step(input bit st, input bit bt, input logic [31:0] tgt, input bit ack);
        bit          pop, accept;
        logic [31:0] base;
        pop    = (m_q.size() != 0) && !st && !bt;
        accept = ack && m_busy && !m_stale && !bt;
        if (bt) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back(m_req);
        end
        base = bt ? tgt : m_pc;
        if (!m_busy || ack) begin
            if (m_q.size() < 2) begin
                m_busy = 1; m_stale = 0; m_req = base; m_pc = base + 32'd4;
            end else begin
                m_busy = 0; m_stale = 0;
                if (bt) m_pc = tgt;
            end
        end else if (bt) begin
            m_stale = 1;
            m_pc    = tgt;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("ImReq", {31'b0, ImReq}, {31'b0, m_busy});
            if (m_busy) check("ImAddr", ImAddr, m_req);
            check("OutValid", {31'b0, OutValid}, {31'b0, (m_q.size() != 0)});
            if (m_q.size() != 0) begin
                check("OutPC", OutPC, m_q[0]);
                check("OutAdd1", OutAdd1, m_q[0] + 32'd4);
                check("OutIns", OutIns, word_of(m_q[0]));
            end else begin
                check("OutIns_nop", OutIns, 32'h0);
            end
        end
    end

    // Called at negedge+1: drive one cycle of inputs, advance the model, return at next negedge+1.
    task automatic tick(input logic st, input logic bt, input logic [31:0] tgt);
        logic ack;
        Stall = st; BranchTaken = bt; BranchTarget = tgt;
        ack = 1'b0;
        if (ImReq) begin
            if (!mem_act) begin
                mem_act  = 1;
                mem_left = lat_rand ? int'($urandom_range(0, 3)) : lat;
            end
            if (mem_left == 0) begin
                ack = 1'b1; mem_act = 0;
            end else begin
                mem_left--;
            end
        end else begin
            ack = tie;
        end
        ImAck  = ack;
        ImData = word_of(ImAddr);
        model_step(st, bt, tgt, ack);
        @(negedge CLK); #1;
    endtask

    task automatic do_reset(input int new_lat, input bit new_tie, input bit new_rand);
        RST = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; ImAck = 1'b0;
        #1;
        model_reset();
        mem_act = 0; lat = new_lat; tie = new_tie; lat_rand = new_rand;
        @(negedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        bit          st, bt;
        logic [31:0] tgt;

        @(negedge CLK); #1;
        check("rst_ImReq", {31'b0, ImReq}, 32'h0);
        check("rst_ImAddr", ImAddr, 32'h0);
        check("rst_OutValid", {31'b0, OutValid}, 32'h0);
        check("rst_OutPC", OutPC, 32'h0);
        check("rst_OutAdd1", OutAdd1, 32'h0);
        check("rst_OutIns", OutIns, 32'h0);
        chk_en = 1;

        // Zero-wait memory.
        do_reset(0, 1, 0);
        tick(0, 0, 0);
        check("zw_req", {31'b0, ImReq}, 32'h1);
        check("zw_addr", ImAddr, 32'h0);
        check("zw_v0", {31'b0, OutValid}, 32'h0);
        tick(0, 0, 0);
        check("zw_v1", {31'b0, OutValid}, 32'h1);
        check("zw_pc0", OutPC, 32'h0);
        check("zw_add0", OutAdd1, 32'h4);
        check("zw_ins0", OutIns, 32'h5A5A_C3C3);
        tick(0, 0, 0); check("zw_pc4", OutPC, 32'h4);
        tick(0, 0, 0); check("zw_pc8", OutPC, 32'h8);
        tick(0, 0, 0); check("zw_pc12", OutPC, 32'hC);

        // Two wait states per request.
        do_reset(2, 0, 0);
        repeat (3) tick(0, 0, 0);
        check("w2_v_e3", {31'b0, OutValid}, 32'h0);
        tick(0, 0, 0); check("w2_pc0", OutPC, 32'h0);
        tick(0, 0, 0); check("w2_addr_e5", ImAddr, 32'h4);
        tick(0, 0, 0); check("w2_addr_e6", ImAddr, 32'h4);
        tick(0, 0, 0); check("w2_pc4", OutPC, 32'h4);
        repeat (3) tick(0, 0, 0);
        check("w2_pc8", OutPC, 32'h8);

        // Stall fills the queue, then release.
        do_reset(0, 1, 0);
        repeat (2) tick(0, 0, 0);
        repeat (6) tick(1, 0, 0);
        check("st_req_off", {31'b0, ImReq}, 32'h0);
        check("st_pc0", OutPC, 32'h0);
        tick(0, 0, 0);
        check("st_rel_pc4", OutPC, 32'h4);
        check("st_rel_addr", ImAddr, 32'h8);
        tick(0, 0, 0); check("st_pc8", OutPC, 32'h8);
        tick(0, 0, 0); check("st_pc12", OutPC, 32'hC);

        // Redirect while the fetch of 8 is outstanding.
        do_reset(3, 0, 0);
        repeat (9) tick(0, 0, 0);
        check("br_pre_pc", OutPC, 32'h4);
        tick(0, 1, 32'h40);
        check("br_flush", {31'b0, OutValid}, 32'h0);
        check("br_drop_addr", ImAddr, 32'h8);
        repeat (2) tick(0, 0, 0);
        check("br_hold_addr", ImAddr, 32'h8);
        tick(0, 0, 0);
        check("br_new_addr", ImAddr, 32'h40);
        repeat (3) tick(0, 0, 0);
        check("br_v_e16", {31'b0, OutValid}, 32'h0);
        tick(0, 0, 0);
        check("br_pc40", OutPC, 32'h40);

        // Redirect with ack and stall at a full queue.
        do_reset(0, 1, 0);
        repeat (2) tick(0, 0, 0);
        tick(1, 0, 0);
        check("bf_idle", {31'b0, ImReq}, 32'h0);
        tick(1, 1, 32'h100);
        check("bf_flush", {31'b0, OutValid}, 32'h0);
        check("bf_addr", ImAddr, 32'h100);
        tick(0, 0, 0);
        check("bf_pc", OutPC, 32'h100);

        // Address wrap at the top of the space.
        tick(0, 1, 32'hFFFF_FFF8);
        tick(0, 0, 0); check("wr_pc_f8", OutPC, 32'hFFFF_FFF8);
        tick(0, 0, 0);
        check("wr_pc_fc", OutPC, 32'hFFFF_FFFC);
        check("wr_add1", OutAdd1, 32'h0);
        tick(0, 0, 0); check("wr_pc_0", OutPC, 32'h0);

        // Reset in BUSY with one queued word.
        do_reset(3, 0, 0);
        repeat (5) tick(1, 0, 0);
        check("mr_pre_v", {31'b0, OutValid}, 32'h1);
        check("mr_pre_req", {31'b0, ImReq}, 32'h1);
        RST = 1'b1;
        #1;
        check("mr_v", {31'b0, OutValid}, 32'h0);
        check("mr_req", {31'b0, ImReq}, 32'h0);
        check("mr_addr", ImAddr, 32'h0);
        check("mr_pc", OutPC, 32'h0);
        check("mr_add1", OutAdd1, 32'h0);
        check("mr_ins", OutIns, 32'h0);
        do_reset(3, 0, 0);
        tick(0, 0, 0);
        check("mr_restart", ImAddr, 32'h0);

        // Random traffic.
        do_reset(0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            st  = ($urandom_range(0, 9) < 3);
            bt  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            tick(st, bt, tgt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
